// File: rtl/axis_upsizer.sv
// axis_upsizer: AXI-Stream width up-converter.
// Packs RATIO = DW_OUT/DW_IN narrow input beats into one wide output word.
// The first beat goes in lane 0, which holds the least-significant bits.
// s_tlast flushes a partial word early; the unwritten lanes read 0 and have
// keep=0. The output word sits in a register and supports full back-pressure.
//
// Ports:
//   clk, reset           single clock; asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast   narrow input stream
//   m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast   wide output stream
//
// Output stage states:
//   state     | meaning
//   OUT_EMPTY | no word held, m_tvalid=0
//   OUT_FULL  | word held in output register, m_tvalid=1
module axis_upsizer #(
   parameter  int DW_IN  = 8,
   parameter  int DW_OUT = 32,
   localparam int RATIO  = DW_OUT / DW_IN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DW_IN-1:0]  s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [DW_OUT-1:0] m_tdata,
   output logic [RATIO-1:0]  m_tkeep,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast
);

   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   if ((DW_IN < 1) || (DW_OUT < DW_IN) || ((DW_OUT % DW_IN) != 0)) begin : g_bad_width
      $error("axis_upsizer: DW_OUT must be a positive integer multiple of DW_IN");
   end

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   out_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DW_OUT-1:0] acc_q, acc_d;
   logic [RATIO-1:0]  keep_q, keep_d;
   logic [DW_OUT-1:0] data_q, data_d;
   logic [RATIO-1:0]  tkeep_q, tkeep_d;
   logic              tlast_q, tlast_d;

   logic              in_hs;
   logic              complete;
   logic [DW_OUT-1:0] acc_merge;
   logic [RATIO-1:0]  keep_merge;

   // Input is held off whenever the output register cannot take a new word,
   // even for beats that would not complete one. This keeps the pack stage
   // simple: a completing beat can always load the output register.
   assign s_tready = !reset && ((state_q == OUT_EMPTY) || m_tready);
   assign m_tvalid = (state_q == OUT_FULL);
   assign m_tdata  = data_q;
   assign m_tkeep  = tkeep_q;
   assign m_tlast  = tlast_q;

   assign in_hs    = s_tvalid && s_tready;
   assign complete = in_hs && (s_tlast || (cnt_q == CNT_LAST));

   // Current beat merged into the accumulator. s_tdata only reaches the
   // registers through the in_hs-qualified paths below, so garbage on an
   // idle bus never lands in the accumulator.
   always_comb begin
      acc_merge  = acc_q;
      keep_merge = keep_q;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            acc_merge[k*DW_IN +: DW_IN] = s_tdata;
            keep_merge[k]               = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      keep_d = keep_q;
      if (in_hs) begin
         if (complete) begin
            cnt_d  = '0;
            acc_d  = '0;
            keep_d = '0;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            acc_d  = acc_merge;
            keep_d = keep_merge;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      tkeep_d = tkeep_q;
      tlast_d = tlast_q;
      case (state_q)
         OUT_EMPTY: begin
            if (complete) begin
               state_d = OUT_FULL;
               data_d  = acc_merge;
               tkeep_d = keep_merge;
               tlast_d = s_tlast;
            end
         end
         OUT_FULL: begin
            // A completing beat here implies m_tready (s_tready gating), so
            // the held word drains and the new one loads with no bubble.
            if (complete) begin
               data_d  = acc_merge;
               tkeep_d = keep_merge;
               tlast_d = s_tlast;
            end else if (m_tready) begin
               state_d = OUT_EMPTY;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= OUT_EMPTY;
         cnt_q   <= '0;
         acc_q   <= '0;
         keep_q  <= '0;
         data_q  <= '0;
         tkeep_q <= '0;
         tlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         keep_q  <= keep_d;
         data_q  <= data_d;
         tkeep_q <= tkeep_d;
         tlast_q <= tlast_d;
      end
   end

endmodule

// File: tb/tb_axis_upsizer.sv
module tb_axis_upsizer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tvalid, m_tready, m_tlast;

   logic [7:0]  u_s_tdata;
   logic        u_s_tvalid, u_s_tlast, u_s_tready;
   logic [7:0]  u_m_tdata;
   logic [0:0]  u_m_tkeep;
   logic        u_m_tvalid, u_m_tready, u_m_tlast;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   logic [7:0] cur_q[$];
   word_t      exp_q[$];
   int         out_cyc_q[$];

   always #5 clk = ~clk;

   axis_upsizer #(.DW_IN(8), .DW_OUT(32)) dut (
      .clk(clk), .reset(reset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast)
   );

   axis_upsizer #(.DW_IN(8), .DW_OUT(8)) dut_r1 (
      .clk(clk), .reset(reset),
      .s_tdata(u_s_tdata), .s_tvalid(u_s_tvalid), .s_tready(u_s_tready), .s_tlast(u_s_tlast),
      .m_tdata(u_m_tdata), .m_tkeep(u_m_tkeep), .m_tvalid(u_m_tvalid), .m_tready(u_m_tready),
      .m_tlast(u_m_tlast)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: beats collected into a list; a word is formed from the
   // list when it reaches 4 beats or a tlast beat arrives. Words wait in a
   // queue until the downstream handshake, so m_tvalid must equal "queue
   // not empty" on every cycle.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_m_tdata", m_tdata, 0);
         chk("rst_m_tkeep", m_tkeep, 0);
         chk("rst_m_tlast", m_tlast, 0);
         chk("rst_s_tready", s_tready, 0);
         cur_q.delete();
         exp_q.delete();
      end else begin
         chk("m_tvalid", m_tvalid, exp_q.size() != 0);
         chk("s_tready", s_tready, (exp_q.size() == 0) || m_tready);
         if (m_tvalid && m_tready && exp_q.size() != 0) begin
            chk("m_tdata", m_tdata, exp_q[0].d);
            chk("m_tkeep", m_tkeep, exp_q[0].k);
            chk("m_tlast", m_tlast, exp_q[0].l);
            void'(exp_q.pop_front());
            out_cyc_q.push_back(cyc);
         end
         if (s_tvalid && s_tready) begin
            cur_q.push_back(s_tdata);
            if (cur_q.size() == 4 || s_tlast) begin
               word_t w;
               w.d = 32'h0;
               for (int i = 0; i < cur_q.size(); i++) w.d = w.d | (32'(cur_q[i]) << (8 * i));
               w.k = 4'((1 << cur_q.size()) - 1);
               w.l = s_tlast;
               exp_q.push_back(w);
               cur_q.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      s_tvalid = 1'b0;
      s_tdata  = 8'($urandom);
      s_tlast  = 1'($urandom);
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int  n = 0;
      logic acc = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      do begin
         @(negedge clk);
         acc = s_tready;
         tick();
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("send_timeout", 0, 1);
      idle_bus();
   endtask

   logic [31:0] held;

   initial begin
      reset = 1'b1;
      m_tready = 1'b1;
      idle_bus();
      u_s_tvalid = 1'b0; u_s_tdata = 8'h00; u_s_tlast = 1'b0; u_m_tready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", s_tready, 1);
      tick();

      // Four-beat packet with tlast on the last beat
      send(8'h68, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
      @(negedge clk);
      chk("t1_valid", m_tvalid, 1);
      chk("t1_data", m_tdata, 32'h03020168);
      chk("t1_keep", m_tkeep, 4'b1111);
      chk("t1_last", m_tlast, 1);
      tick();
      @(negedge clk);
      chk("t1_valid_one_cycle", m_tvalid, 0);
      tick();

      // Early flush, then a full word restarting at lane 0
      send(8'hAA, 0); send(8'hBB, 1);
      @(negedge clk);
      chk("t2_data", m_tdata, 32'h0000BBAA);
      chk("t2_keep", m_tkeep, 4'b0011);
      chk("t2_last", m_tlast, 1);
      tick();
      send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
      @(negedge clk);
      chk("t2b_data", m_tdata, 32'h14131211);
      chk("t2b_keep", m_tkeep, 4'b1111);
      chk("t2b_last", m_tlast, 0);
      tick();

      // Stall: output full, beats pending upstream
      m_tready = 1'b0;
      send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 1);
      s_tvalid = 1'b1; s_tdata = 8'h21; s_tlast = 1'b0;
      @(negedge clk);
      held = m_tdata;
      chk("t3_held_data", held, 32'h34333231);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_stall_ready", s_tready, 0);
         chk("t3_stall_data", m_tdata, held);
         tick();
      end
      m_tready = 1'b1;
      send(8'h21, 0); send(8'h22, 1);
      // Single-beat packets back-to-back: each completes as the previous drains
      send(8'h77, 1); send(8'h78, 1);
      @(negedge clk);
      chk("t3_nobubble_valid", m_tvalid, 1);
      chk("t3_nobubble_data", m_tdata, 32'h00000078);
      tick(); tick();

      // Continuous stream: 3 words, 4 cycles apart
      out_cyc_q.delete();
      for (int i = 0; i < 12; i++) send(8'(8'h40 + i), 0);
      repeat (3) tick();
      chk("t4_words", out_cyc_q.size(), 3);
      if (out_cyc_q.size() == 3) begin
         chk("t4_gap1", out_cyc_q[1] - out_cyc_q[0], 4);
         chk("t4_gap2", out_cyc_q[2] - out_cyc_q[1], 4);
      end

      // Reset mid-word discards the partial beats
      send(8'hE1, 0); send(8'hE2, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      @(negedge clk);
      chk("t5_data", m_tdata, 32'h04030201);
      chk("t5_keep", m_tkeep, 4'b1111);
      tick();

      // RATIO==1 pass-through
      u_s_tvalid = 1'b1; u_s_tdata = 8'h5A; u_s_tlast = 1'b1;
      @(negedge clk);
      chk("r1_ready", u_s_tready, 1);
      chk("r1_valid_before", u_m_tvalid, 0);
      tick();
      u_s_tvalid = 1'b0; u_s_tdata = 8'hC3; u_s_tlast = 1'b0;
      @(negedge clk);
      chk("r1_valid", u_m_tvalid, 1);
      chk("r1_data", u_m_tdata, 8'h5A);
      chk("r1_keep", u_m_tkeep, 1'b1);
      chk("r1_last", u_m_tlast, 1);
      tick();

      // Random traffic with random back-pressure and idle-bus garbage
      for (int i = 0; i < 1500; i++) begin
         s_tvalid = ($urandom_range(0, 9) < 7);
         s_tdata  = 8'($urandom);
         s_tlast  = ($urandom_range(0, 9) < 2);
         m_tready = ($urandom_range(0, 9) < 6);
         tick();
      end
      idle_bus();
      m_tready = 1'b1;
      repeat (4) tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
